// File: rtl/pe_array_feeder.sv
// Weight preload and skewed activation feeder for an NxN weight-stationary PE array; weights appear 1 cycle after accept, lane i 1+i*STAGGER cycles after accept.
// Backpressure: w_ready/x_ready follow the FSM mode; downstream never stalls, so the lane delay lines shift every cycle.
module pe_array_feeder #(
  parameter int N          = 5,
  parameter int PORT_WIDTH = 8,
  parameter int STAGGER    = 4,
  parameter int LOC_W      = (N * N > 1) ? $clog2(N * N) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [PORT_WIDTH-1:0]   w_data,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic                    x_last,
  input  logic [N*PORT_WIDTH-1:0] a_vec,
  input  logic [N*PORT_WIDTH-1:0] b_vec,
  output logic                    wori,
  output logic [PORT_WIDTH-1:0]   weight_in,
  output logic [LOC_W-1:0]        weight_location,
  output logic [N*PORT_WIDTH-1:0] a_out,
  output logic [N*PORT_WIDTH-1:0] b_out,
  output logic [N-1:0]            lane_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int NN        = N * N;
  localparam int DRAIN_CYC = (N - 1) * STAGGER;
  localparam int DCNT_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam bit NO_DRAIN  = (DRAIN_CYC == 0);

  typedef enum logic [1:0] {IDLE, LOAD, FEED, DRAIN} state_t;

  typedef struct packed {
    logic                  vld;
    logic [PORT_WIDTH-1:0] a;
    logic [PORT_WIDTH-1:0] b;
  } lane_t;

  state_t             state;
  state_t             state_nxt;
  logic               loaded;
  logic [LOC_W-1:0]   wcnt;
  logic [DCNT_W-1:0]  dcnt;
  logic               w_acc;
  logic               x_acc;
  logic               w_final;
  logic               x_final;

  assign w_acc   = w_valid & w_ready;
  assign x_acc   = x_valid & x_ready;
  assign w_final = w_acc & (wcnt == LOC_W'(NN - 1));
  assign x_final = x_acc & x_last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (w_acc)        state_nxt = w_final ? FEED : LOAD;
        else if (x_final) state_nxt = NO_DRAIN ? IDLE : DRAIN;
        else if (x_acc)   state_nxt = FEED;
      end
      LOAD:  if (w_final) state_nxt = FEED;
      FEED:  if (x_final) state_nxt = NO_DRAIN ? IDLE : DRAIN;
      DRAIN: if (dcnt == DCNT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Weights win over activations when both are offered in IDLE.
  always_comb begin
    w_ready = 1'b0;
    x_ready = 1'b0;
    busy    = (state != IDLE);
    case (state)
      IDLE: begin
        w_ready = 1'b1;
        x_ready = loaded & ~w_valid;
      end
      LOAD:    w_ready = 1'b1;
      FEED:    x_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loaded          <= 1'b0;
      wcnt            <= '0;
      dcnt            <= '0;
      wori            <= 1'b0;
      weight_in       <= '0;
      weight_location <= '0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_acc) begin
        weight_in       <= w_data;
        weight_location <= wcnt;
        wori            <= 1'b1;
        if (w_final) begin
          wcnt   <= '0;
          loaded <= 1'b1;
        end else begin
          wcnt   <= wcnt + LOC_W'(1);
          loaded <= 1'b0;
        end
      end else if (state != LOAD) begin
        wori            <= 1'b0;
        weight_in       <= '0;
        weight_location <= '0;
      end
      if (x_final) begin
        dcnt <= DCNT_W'(DRAIN_CYC);
        done <= NO_DRAIN;
      end else if (state == DRAIN) begin
        dcnt <= dcnt - DCNT_W'(1);
        if (dcnt == DCNT_W'(1)) done <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int DEPTH = 1 + i * STAGGER;
    lane_t head;
    lane_t line [DEPTH];

    always_comb begin
      head = '0;
      if (x_acc) begin
        head.vld = 1'b1;
        head.a   = a_vec[i*PORT_WIDTH +: PORT_WIDTH];
        head.b   = b_vec[i*PORT_WIDTH +: PORT_WIDTH];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < DEPTH; k++) line[k] <= '0;
      end else begin
        line[0] <= head;
        for (int k = 1; k < DEPTH; k++) line[k] <= line[k-1];
      end
    end

    assign a_out[i*PORT_WIDTH +: PORT_WIDTH] = line[DEPTH-1].a;
    assign b_out[i*PORT_WIDTH +: PORT_WIDTH] = line[DEPTH-1].b;
    assign lane_valid[i]                     = line[DEPTH-1].vld;
  end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Directed bench: main instance N=5/STAGGER=4 with an edge-indexed lane/done model, second instance N=2/STAGGER=0.
module tb_pe_array_feeder;
  localparam int N  = 5;
  localparam int PW = 8;
  localparam int S  = 4;
  localparam int LW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            w_valid, w_ready, x_valid, x_ready, x_last;
  logic [PW-1:0]   w_data, weight_in;
  logic [N*PW-1:0] a_vec, b_vec, a_out, b_out;
  logic            wori, busy, done;
  logic [LW-1:0]   weight_location;
  logic [N-1:0]    lane_valid;

  logic            w_valid0, w_ready0, x_valid0, x_ready0, x_last0;
  logic [PW-1:0]   w_data0, weight_in0;
  logic [2*PW-1:0] a_vec0, b_vec0, a_out0, b_out0;
  logic            wori0, busy0, done0;
  logic [1:0]      weight_location0;
  logic [1:0]      lane_valid0;

  pe_array_feeder #(.N(N), .PORT_WIDTH(PW), .STAGGER(S)) dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_last(x_last),
    .a_vec(a_vec), .b_vec(b_vec),
    .wori(wori), .weight_in(weight_in), .weight_location(weight_location),
    .a_out(a_out), .b_out(b_out), .lane_valid(lane_valid),
    .busy(busy), .done(done)
  );

  pe_array_feeder #(.N(2), .PORT_WIDTH(PW), .STAGGER(0)) dut0 (
    .clk(clk), .rst(rst),
    .w_valid(w_valid0), .w_ready(w_ready0), .w_data(w_data0),
    .x_valid(x_valid0), .x_ready(x_ready0), .x_last(x_last0),
    .a_vec(a_vec0), .b_vec(b_vec0),
    .wori(wori0), .weight_in(weight_in0), .weight_location(weight_location0),
    .a_out(a_out0), .b_out(b_out0), .lane_valid(lane_valid0),
    .busy(busy0), .done(done0)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int e = 0;
  int rst_edge = -1;
  bit hist_v [1024];
  int hist_b [1024];
  bit done_at[1024];
  bit head_v, head_last;
  int head_b;

  typedef struct {
    bit         wv;
    logic [7:0] wd;
    bit         exp_wr;
    bit         exp_wori;
    logic [7:0] exp_win;
    int         exp_loc;
  } wvec_t;
  wvec_t wtab[27];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, e, act, exp);
    end
  endtask

  task automatic check_lanes();
    for (int i = 0; i < N; i++) begin
      int idx;
      bit v;
      logic [7:0] ea, eb;
      idx = e - i * S;
      v = 1'b0;
      ea = 8'h00;
      eb = 8'h00;
      if (idx > rst_edge && hist_v[idx]) begin
        v  = 1'b1;
        ea = 8'(i * 10 + hist_b[idx]);
        eb = 8'(-hist_b[idx]);
      end
      chk($sformatf("lane%0d_valid", i), 32'(lane_valid[i]), 32'(v));
      chk($sformatf("lane%0d_a", i), 32'(a_out[i*PW +: PW]), 32'(ea));
      chk($sformatf("lane%0d_b", i), 32'(b_out[i*PW +: PW]), 32'(eb));
    end
    chk("done", 32'(done), 32'(done_at[e]));
  endtask

  // One clock edge: log what the model expects to enter the line heads, then check the outputs.
  task automatic tick();
    @(posedge clk);
    e++;
    hist_v[e] = head_v && !rst;
    hist_b[e] = head_b;
    if (rst) begin
      rst_edge = e;
      for (int k = e; k < 1024; k++) done_at[k] = 1'b0;
    end else if (head_v && head_last) begin
      done_at[e + S * (N - 1)] = 1'b1;
    end
    #1;
    check_lanes();
    head_v    = 1'b0;
    head_last = 1'b0;
  endtask

  task automatic set_x(input bit v, input bit last, input int beat);
    x_valid = v;
    x_last  = last;
    for (int i = 0; i < N; i++) begin
      a_vec[i*PW +: PW] = 8'(i * 10 + beat);
      b_vec[i*PW +: PW] = 8'(-beat);
    end
  endtask

  task automatic beat_x(input bit last, input int beat, input bit exp_rdy);
    set_x(1'b1, last, beat);
    #1;
    chk("x_ready", 32'(x_ready), 32'(exp_rdy));
    head_v    = exp_rdy;
    head_b    = beat;
    head_last = last & exp_rdy;
    tick();
  endtask

  task automatic idle_ticks(input int n);
    x_valid = 1'b0;
    x_last  = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int j;
    j = 0;
    for (int k = 0; k < 25; k++) begin
      wtab[j] = '{1'b1, 8'(k + 1), 1'b1, 1'b1, 8'(k + 1), k};
      j++;
      if (k == 10) begin
        wtab[j] = '{1'b0, 8'hEE, 1'b1, 1'b1, 8'd11, 10};
        j++;
      end
    end
    wtab[26] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0};

    head_v = 1'b0; head_last = 1'b0; head_b = 0;
    rst = 1'b1;
    w_valid = 1'b1; w_data = 8'hA5;
    x_valid = 1'b1; x_last = 1'b1;
    a_vec = {$urandom, $urandom};
    b_vec = {$urandom, $urandom};
    w_valid0 = 1'b0; w_data0 = '0; x_valid0 = 1'b0; x_last0 = 1'b0;
    a_vec0 = '0; b_vec0 = '0;

    // Reset with garbage on the inputs.
    repeat (3) tick();
    chk("rst_w_ready", 32'(w_ready), 32'd1);
    chk("rst_x_ready", 32'(x_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wori", 32'(wori), 32'd0);
    chk("rst_weight_in", 32'(weight_in), 32'd0);
    chk("rst_weight_loc", 32'(weight_location), 32'd0);
    rst = 1'b0;
    w_valid = 1'b0; x_valid = 1'b0; x_last = 1'b0;

    // Activations are refused while no weight set is held.
    set_x(1'b1, 1'b0, 3);
    #1;
    chk("unloaded_x_ready", 32'(x_ready), 32'd0);
    tick();
    chk("unloaded_busy", 32'(busy), 32'd0);
    x_valid = 1'b0;

    // Weight load with a one-cycle gap after k=10.
    for (int k = 0; k < 27; k++) begin
      w_valid = wtab[k].wv;
      w_data  = wtab[k].wd;
      #1;
      chk($sformatf("wl%0d_w_ready", k), 32'(w_ready), 32'(wtab[k].exp_wr));
      tick();
      chk($sformatf("wl%0d_wori", k), 32'(wori), 32'(wtab[k].exp_wori));
      chk($sformatf("wl%0d_weight_in", k), 32'(weight_in), 32'(wtab[k].exp_win));
      chk($sformatf("wl%0d_loc", k), 32'(weight_location), 32'(wtab[k].exp_loc));
    end

    // Staggered feed of 25 beats, then drain with a refused weight offer.
    for (int b = 0; b < 25; b++) beat_x(b == 24, b, 1'b1);
    x_valid = 1'b0; x_last = 1'b0;
    w_valid = 1'b1; w_data = 8'h99;
    for (int k = 1; k <= 20; k++) begin
      if (k == 6) w_valid = 1'b0;
      #1;
      if (k <= 16) begin
        chk("drain_x_ready", 32'(x_ready), 32'd0);
        chk("drain_w_ready", 32'(w_ready), 32'd0);
      end
      tick();
      if (k < 16)  chk("drain_busy", 32'(busy), 32'd1);
      if (k == 16) chk("done_busy", 32'(busy), 32'd0);
      if (k == 17) chk("after_done_lane4", 32'(lane_valid[4]), 32'd0);
    end
    chk("drain_wori", 32'(wori), 32'd0);

    // Reuse without reload, with a bubble and a stray x_last while x_valid is low.
    beat_x(1'b0, 30, 1'b1);
    beat_x(1'b0, 31, 1'b1);
    set_x(1'b0, 1'b1, 77);
    #1;
    chk("gap_x_ready", 32'(x_ready), 32'd1);
    tick();
    beat_x(1'b1, 32, 1'b1);
    idle_ticks(20);
    chk("bubble_busy", 32'(busy), 32'd0);

    // Weight wins over x in IDLE.
    w_valid = 1'b1; w_data = 8'h42;
    set_x(1'b1, 1'b0, 40);
    #1;
    chk("prio_x_ready", 32'(x_ready), 32'd0);
    chk("prio_w_ready", 32'(w_ready), 32'd1);
    tick();
    chk("prio_wori", 32'(wori), 32'd1);
    chk("prio_weight_in", 32'(weight_in), 32'h42);
    chk("prio_loc", 32'(weight_location), 32'd0);
    chk("prio_busy", 32'(busy), 32'd1);
    for (int k = 1; k < 25; k++) begin
      w_data = 8'(k);
      #1;
      if (k == 1) chk("load_x_ready", 32'(x_ready), 32'd0);
      tick();
    end
    w_valid = 1'b0;
    x_valid = 1'b0;

    // Reset in the middle of FEED.
    for (int b = 50; b < 55; b++) beat_x(1'b0, b, 1'b1);
    rst = 1'b1;
    set_x(1'b1, 1'b0, 55);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_x_ready", 32'(x_ready), 32'd0);
    chk("midrst_w_ready", 32'(w_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    idle_ticks(1);

    // STAGGER=0 instance: single beat, done in the same cycle as the lanes.
    for (int k = 1; k <= 4; k++) begin
      w_valid0 = 1'b1;
      w_data0  = 8'(k);
      tick();
    end
    chk("s0_wori", 32'(wori0), 32'd1);
    chk("s0_weight_in", 32'(weight_in0), 32'd4);
    chk("s0_loc", 32'(weight_location0), 32'd3);
    w_valid0 = 1'b0;
    x_valid0 = 1'b1; x_last0 = 1'b1;
    a_vec0 = 16'h0605;
    b_vec0 = 16'hFAFB;
    #1;
    chk("s0_x_ready", 32'(x_ready0), 32'd1);
    chk("s0_w_ready", 32'(w_ready0), 32'd0);
    tick();
    x_valid0 = 1'b0; x_last0 = 1'b0;
    chk("s0_a_out", 32'(a_out0), 32'h0605);
    chk("s0_b_out", 32'(b_out0), 32'hFAFB);
    chk("s0_lane_valid", 32'(lane_valid0), 32'd3);
    chk("s0_done", 32'(done0), 32'd1);
    chk("s0_busy", 32'(busy0), 32'd0);
    chk("s0_wori_off", 32'(wori0), 32'd0);
    tick();
    chk("s0_done_pulse", 32'(done0), 32'd0);
    chk("s0_lane_valid_off", 32'(lane_valid0), 32'd0);
    chk("s0_a_out_off", 32'(a_out0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_array_feeder.md
# pe_array_feeder

Parametrised front-end sequencer for the N×N weight-stationary PE array. It preloads the array's N·N weights from a ready/valid stream by driving WorI, weight_in and weight_location. It then streams activation/partial-sum vectors into the array's a/b edge ports, delaying lane i by i·STAGGER cycles and draining with zero bubbles. It replaces the hand-coded weight-load and stagger sequencing previously done outside the array.

## Interface
Parameters:
- N, 5, array dimension: lanes per side and N·N weights.
- PORT_WIDTH, 8, signed word width of weights and a/b lanes.
- STAGGER, 4, per-lane skew in cycles. 0 is legal.
- LOC_W, $clog2(N*N) (minimum 1), weight_location width.

Ports:
- clk in 1: the single clock. All logic is on its rising edge.
- rst in 1: synchronous, active-high reset.
- w_valid in 1, w_ready out 1, w_data in PORT_WIDTH: weight stream, row-major, location 0 first.
- x_valid in 1, x_ready out 1, x_last in 1: activation-beat handshake. x_last marks the final beat of a burst.
- a_vec in N·PORT_WIDTH: lane i occupies bits [i·PORT_WIDTH +: PORT_WIDTH].
- b_vec in N·PORT_WIDTH: same lane layout as a_vec.
- wori out 1: array mode. 1 means weight preload.
- weight_in out PORT_WIDTH, weight_location out LOC_W: weight write to the array.
- a_out out N·PORT_WIDTH, b_out out N·PORT_WIDTH: skewed lanes, wired to a*_in/b*_in of the array.
- lane_valid out N: lane i is carrying real data this cycle.
- busy out 1: state ≠ IDLE.
- done out 1: one-cycle pulse at the end of a burst.

## Operation
- FSM states: IDLE, LOAD, FEED, DRAIN. An internal flag `loaded` records that a full weight set is held.
- **IDLE**
  - w_ready=1.
  - x_ready=loaded & ~w_valid. Weights take priority when both valids are high.
  - Accepted weight beat → LOAD.
  - Accepted x beat → FEED.
- **LOAD**
  - w_ready=1, x_ready=0.
  - Each accepted beat registers weight_in←w_data, weight_location←wcnt, wori←1, then increments wcnt.
  - The N·N-th accepted beat sets loaded=1, clears wcnt, and moves to FEED.
  - A gap in w_valid holds the outputs and wcnt.
  - Writing a new set clears loaded at its first beat.
- **FEED**
  - x_ready=1, w_ready=0.
  - Lane i has a delay line of 1+i·STAGGER registers, for both a and b.
  - An accepted beat enters all lanes' line heads with valid=1.
  - A cycle with no beat enters 0 with valid=0.
  - The lines shift every cycle; downstream never stalls.
  - Accepting a beat with x_last=1 loads dcnt←(N-1)·STAGGER and moves to DRAIN. If STAGGER=0, done is raised next cycle and the FSM goes straight to IDLE.
- **DRAIN**
  - x_ready=0, w_ready=0.
  - Zeros enter the line heads with valid=0, and dcnt decrements.
  - At dcnt=1, the next edge raises done for one cycle and returns the FSM to IDLE.
- wori deasserts on the edge after the final weight is written. weight_in and weight_location return to 0 at the same time.
- Arithmetic: pure pass-through; data is never modified. Bubbles are signed 0.

## Timing
- Reset (any state, including mid-LOAD or mid-FEED) forces, on the next edge:
  - all outputs to 0;
  - state=IDLE, loaded=0, wcnt=dcnt=0;
  - every delay line and every valid bit to 0.
- After that edge, w_ready=1 and x_ready=0.
- Weight latency: the beat accepted at edge t appears on weight_in/weight_location/wori from t+1.
- Lane latency: the x beat accepted at edge t appears on lane i at t+1+i·STAGGER, with lane_valid[i]=1.
- Lane 0 therefore has exactly one register of latency.
- Done: last beat accepted at edge t gives done=1 during cycle t+1+(N-1)·STAGGER. This is the same cycle that lane N-1 presents the last valid data. busy falls in that cycle too.
- Back-to-back bursts: a new beat may be accepted in the cycle after done. Lines still shift independently, so there is no overlap hazard.
- Single-beat burst: x_valid and x_last high on the first FEED beat is legal, and drain proceeds normally.
- x_last while x_valid=0 is ignored.
- w_valid during FEED or DRAIN is not accepted and waits.
- x_valid in IDLE with loaded=0 is not accepted.

## Test plan
- **Reset:** drive garbage on all inputs, then rst for 3 cycles.
  - Required: every output 0, w_ready=1, x_ready=0, busy=0.
- **Weight load:** N=5, send w_data=k+1 for k=0..24 with a one-cycle w_valid gap after k=10.
  - Required: weight_location 0..24 with weight_in 1..25, each one cycle after its accept.
  - Required: wori high from the first write through k=24, low afterwards, and the gap holds the outputs.
- **Staggered feed:** STAGGER=4, 25 beats with a_vec lane i = i·10+beat and b_vec lane j = -(beat), x_last on beat 24.
  - Required: lane i emits beat 0 at accept+1+4i, with values matching.
  - Required: done exactly at last-accept+17; lane_valid[4] low on the cycle after done.
- **Bubbles and reuse:** in IDLE with loaded=1 and no w_valid, send 3 beats with an x_valid gap between beats 1 and 2.
  - Required: zero/invalid slot propagates down every lane with the same skew; no reload is required.
- **Priority and reset mid-burst:**
  - With w_valid and x_valid both high in IDLE, only the weight beat is accepted.
  - Asserting rst in the middle of FEED clears all lanes and loaded on the next edge, after which x_ready=0.
- **STAGGER=0, single beat:** send one beat with x_last.
  - Required: all lanes output it one cycle later, with done in that same cycle.
